// File: rtl/seq_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub_pkg
// Brief    : Shared types and helpers for the sequential adder/subtractor.
// Revision : 1.0  initial release
// ============================================================================
package seq_addsub_pkg;

  // Control FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation mode as presented on the sub input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Chunk counter width; a single-chunk build still needs a 1-bit counter
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage : seq_addsub_pkg
`default_nettype wire

// File: rtl/seq_addsub_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Brief    : Combinational CHUNK-bit ripple-carry adder built from 1-bit
//            full adders. Also exposes the carry into its top bit so the
//            caller can derive signed overflow.
// Revision : 1.0  initial release
// ============================================================================
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // carry[i] is the carry into bit i; carry[CHUNK] leaves the chunk
  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub
// Brief    : Multi-cycle WIDTH-bit adder/subtractor. Processes CHUNK bits per
//            cycle, LSB chunk first, through one shared chunk adder, with
//            valid/ready handshakes on operand and result sides.
// Revision : 1.0  initial release
// ============================================================================
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int             NCHUNK = WIDTH / CHUNK;
  localparam int             KW     = cnt_width(NCHUNK);
  localparam logic [KW-1:0]  K_LAST = KW'(NCHUNK - 1);

  state_t           state_q,    state_d;
  logic [KW-1:0]    k_q,        k_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;      // already inverted for subtract
  logic             c_q,        c_d;      // running carry between chunks
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q,     zero_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;

  // Select the operand chunk addressed by the chunk counter
  always_comb begin
    a_chunk = a_q[int'(k_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(k_q)*CHUNK +: CHUNK];
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (c_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // Next-state, datapath and flag update logic
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is an accept
        if (in_valid) begin
          a_d     = a;
          b_d     = (sub == MODE_SUB) ? ~b : b;
          c_d     = (sub == MODE_SUB) ? ~carryin : carryin;
          k_d     = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[int'(k_q)*CHUNK +: CHUNK] = chunk_sum;
        c_d = chunk_cout;
        if (k_q == K_LAST) begin
          // Top chunk: its carries are the carries of the whole word
          carryout_d = chunk_cout;
          overflow_d = chunk_cmsb ^ chunk_cout;
          zero_d     = (sum_d == '0);
          state_d    = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // Handshakes are pure state decodes
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule : seq_addsub
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_addsub
// Brief    : Self-checking bench for seq_addsub: directed 32/4 scenarios plus
//            random vectors on 8/8 and 8/1 builds, scoreboard based.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit, 4-bit chunk instance
  logic        in_valid, in_ready, carryin, sub, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        carryout, overflow, zero;

  // Shared stimulus for the two 8-bit instances
  logic       v8, or8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       rdy_a, ov_a, co_a, of_a, z_a;
  logic       rdy_b, ov_b, co_b, of_b, z_b;
  logic [7:0] sum_a, sum_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_main[$];
  exp_t q_a[$];
  exp_t q_b[$];

  seq_addsub #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carryin(carryin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carryout(carryout),
    .overflow(overflow), .zero(zero)
  );

  seq_addsub #(.WIDTH(8), .CHUNK(8)) u_dut_w8c8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy_a),
    .a(a8), .b(b8), .carryin(cin8), .sub(sub8), .out_valid(ov_a),
    .out_ready(or8), .sum(sum_a), .carryout(co_a),
    .overflow(of_a), .zero(z_a)
  );

  seq_addsub #(.WIDTH(8), .CHUNK(1)) u_dut_w8c1 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy_b),
    .a(a8), .b(b8), .carryin(cin8), .sub(sub8), .out_valid(ov_b),
    .out_ready(or8), .sum(sum_b), .carryout(co_b),
    .overflow(of_b), .zero(z_b)
  );

  // Reference: unsigned result/carry and signed-range overflow, w <= 32
  function automatic exp_t model(input int w, input logic [31:0] x,
                                 input logic [31:0] y, input logic cin,
                                 input logic sb);
    exp_t            m;
    longint unsigned mask, ux, uy, full;
    longint          sx, sy, sres, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    ux   = {32'd0, x} & mask;
    uy   = {32'd0, y} & mask;
    sx   = (((ux >> (w - 1)) & 64'd1) != 0) ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy   = (((uy >> (w - 1)) & 64'd1) != 0) ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    smax = longint'(64'd1 << (w - 1)) - 1;
    smin = -longint'(64'd1 << (w - 1));
    if (!sb) begin
      full = ux + uy + 64'(cin);
      sres = sx + sy + longint'(cin);
    end else begin
      full = ux + ((~uy) & mask) + 64'(!cin);
      sres = sx - sy - longint'(cin);
    end
    m.s  = 32'(full & mask);
    m.co = ((full >> w) & 64'd1) != 0;
    m.ov = (sres > smax) || (sres < smin);
    m.z  = (full & mask) == 0;
    return m;
  endfunction

  // Present one operation to the 32-bit instance and record its expectation
  task automatic send_main(input logic [31:0] x, input logic [31:0] y,
                           input logic c, input logic s, input exp_t e);
    int n;
    n = 0;
    a = x; b = y; carryin = c; sub = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; carryin = 1'($urandom); sub = 1'($urandom);
    q_main.push_back(e);
  endtask

  // Wait (bounded) for the 32-bit result; lat counts edges since accept
  task automatic wait_main(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({in_ready, out_valid, sum, carryout, overflow, zero} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b ov=%b sum=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, sum, carryout, overflow, zero);
    end
    n_tests++;
    if ({rdy_a, ov_a, sum_a, rdy_b, ov_b, sum_b} !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state_w8: a rdy=%b ov=%b sum=%h b rdy=%b ov=%b sum=%h",
               rdy_a, ov_a, sum_a, rdy_b, ov_b, sum_b);
    end
  endtask

  task automatic test_add_zero();
    int   lat;
    exp_t e, g;
    send_main(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b1});
    wait_main(lat);
    n_tests++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL add_zero_latency: got %0d required 8", lat);
    end
    e = q_main.pop_front();
    g = '{sum, carryout, overflow, zero};
    n_tests++;
    if (g !== e || !out_valid) begin
      n_fail++; $display("FAIL add_zero_result: got %h required %h (out_valid=%b)", g, e, out_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_zero_handshake: rdy=%b ov=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_signed_ovf();
    int   lat;
    exp_t e, g;
    send_main(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    wait_main(lat);
    e = q_main.pop_front();
    g = '{sum, carryout, overflow, zero};
    n_tests++;
    if (g !== e || lat !== 8) begin
      n_fail++; $display("FAIL signed_ovf: got %h lat %0d required %h lat 8", g, lat, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int   lat;
    exp_t e, g;
    send_main(32'd5, 32'd7, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    wait_main(lat);
    e = q_main.pop_front();
    g = '{sum, carryout, overflow, zero};
    n_tests++;
    if (g !== e) begin
      n_fail++; $display("FAIL sub_borrow: got %h required %h", g, e);
    end
    @(posedge clk); #1;
    send_main(32'd7, 32'd5, 1'b1, 1'b1, '{32'h0000_0001, 1'b1, 1'b0, 1'b0});
    wait_main(lat);
    e = q_main.pop_front();
    g = '{sum, carryout, overflow, zero};
    n_tests++;
    if (g !== e) begin
      n_fail++; $display("FAIL sub_borrow_in: got %h required %h", g, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e, g;
    out_ready = 1'b0;
    send_main(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{32'h2345_678A, 1'b0, 1'b0, 1'b0});
    wait_main(lat);
    e = q_main.pop_front();
    for (int i = 0; i < 10; i++) begin
      g = '{sum, carryout, overflow, zero};
      n_tests++;
      if (g !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %h ov=%b rdy=%b required %h 1 0",
                 i, g, out_valid, in_ready, e);
      end
      if (i == 3) begin
        in_valid = 1'b1; a = 32'h0; b = 32'h0; carryin = 1'b0; sub = 1'b0;
      end else if (i == 5) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: rdy=%b ov=%b required 1 0", in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_ignored_pulse: rdy=%b ov=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    exp_t e, g;
    send_main(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(q_main.pop_back());
    n_tests++;
    if ({in_ready, out_valid, sum, carryout, overflow, zero} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_run: rdy=%b ov=%b sum=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, sum, carryout, overflow, zero);
    end
    send_main(32'd1, 32'd1, 1'b0, 1'b0, '{32'd2, 1'b0, 1'b0, 1'b0});
    wait_main(lat);
    e = q_main.pop_front();
    g = '{sum, carryout, overflow, zero};
    n_tests++;
    if (g !== e || lat !== 8) begin
      n_fail++; $display("FAIL reset_recover: got %h lat %0d required %h lat 8", g, lat, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    exp_t e;
    int   n;
    bit   got_a, got_b;
    for (int i = 0; i < 30; i++) begin
      n = 0;
      while (!(rdy_a && rdy_b) && n < 50) begin
        @(posedge clk); #1; n++;
      end
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom);
      if (i == 0) begin a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; end
      if (i == 1) begin a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; end
      v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
      q_a.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8));
      q_b.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8));
      a8 = 8'($urandom); b8 = 8'($urandom);
      got_a = 1'b0; got_b = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(posedge clk); #1;
        if (ov_a && !got_a) begin
          got_a = 1'b1;
          e = q_a.pop_front();
          n_tests++;
          if ({sum_a, co_a, of_a, z_a} !== {e.s[7:0], e.co, e.ov, e.z} || cyc != 1) begin
            n_fail++;
            $display("FAIL sweep_w8c8[%0d]: got %h %b%b%b lat %0d required %h %b%b%b lat 1",
                     i, sum_a, co_a, of_a, z_a, cyc, e.s[7:0], e.co, e.ov, e.z);
          end
        end
        if (ov_b && !got_b) begin
          got_b = 1'b1;
          e = q_b.pop_front();
          n_tests++;
          if ({sum_b, co_b, of_b, z_b} !== {e.s[7:0], e.co, e.ov, e.z} || cyc != 8) begin
            n_fail++;
            $display("FAIL sweep_w8c1[%0d]: got %h %b%b%b lat %0d required %h %b%b%b lat 8",
                     i, sum_b, co_b, of_b, z_b, cyc, e.s[7:0], e.co, e.ov, e.z);
          end
        end
        if (got_a && got_b) break;
      end
      if (!got_a || !got_b) begin
        n_tests++; n_fail++;
        $display("FAIL sweep_timeout[%0d]: got_a=%b got_b=%b required 1 1", i, got_a, got_b);
        if (!got_a) void'(q_a.pop_front());
        if (!got_b) void'(q_b.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'h0; b = 32'h0; carryin = 1'b0; sub = 1'b0;
    v8 = 1'b0; or8 = 1'b1; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_add_zero();
    test_signed_ovf();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_seq_addsub
`default_nettype wire

// File: doc/seq_addsub.md
# seq_addsub

Multi-cycle, parametrised adder/subtractor that processes a WIDTH-bit operation CHUNK bits per cycle, LSB chunk first, through one reusable chunk adder. It is the sequential successor of the ripple-carry adder datapath and trades latency for area. It also adds a subtract mode, a zero flag and valid/ready handshakes on both sides. It sits between operand registers and the ALU result mux.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK, NCHUNK >= 1.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept; high exactly in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carryin  input  1  add: carry-in; sub: borrow-in.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid; high exactly in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- carryout  output  1  carry out of bit WIDTH-1; in sub mode 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- Arithmetic, all modulo 2^WIDTH:
  - Add: a + b + carryin.
  - Sub: a + ~b + !carryin, i.e. a - b - carryin.
- Accept occurs on the edge where in_valid && in_ready. At accept the block latches a, B' = sub ? ~b : b, and c = sub ? !carryin : carryin. It clears the chunk counter k and the sum register, then enters RUN.
- FSM:
  - IDLE -> RUN on accept.
  - RUN -> RUN while k < NCHUNK-1.
  - RUN -> DONE at the edge that completes chunk NCHUNK-1.
  - DONE -> IDLE on out_valid && out_ready.
- RUN cycle k:
  - sum[k*CHUNK +: CHUNK] <= chunk sum of A, B' chunk k plus c.
  - c <= chunk carry-out.
  - k <= k+1.
- Final chunk also registers:
  - carryout = final chunk carry-out.
  - overflow = carry into bit WIDTH-1 XOR carryout.
  - zero = (complete sum == 0).
- Inputs a, b, carryin and sub are ignored outside the accept edge.
- sum, carryout, overflow and zero are held stable throughout DONE, however long out_ready is low.
- No same-cycle turnaround: the next accept is possible at the earliest one cycle after the output handshake.
- Reset (any state, including mid-RUN or DONE):
  - State goes to IDLE, and the in-flight operation is discarded with no output.
  - in_ready = 1; out_valid, sum, carryout, overflow, zero and k all = 0.

## Timing
- Accept at edge E0. Chunk k is computed combinationally in the cycle after edge Ek and registered at edge E(k+1).
- out_valid rises after edge E(NCHUNK), so latency is NCHUNK cycles from accept.
- Best-case throughput is one operation per NCHUNK+2 cycles: NCHUNK RUN cycles, at least one DONE cycle, and one IDLE cycle.
- in_ready is a pure state decode and has no combinational path from in_valid.
- out_valid is a pure state decode and has no path from out_ready.
- sum bits may change only during RUN; they are meaningful only while out_valid = 1.
- Critical path is one CHUNK-bit ripple plus register setup.
- NCHUNK = 1 is legal: RUN lasts one cycle, latency is 1.

## Structure
- Package seq_addsub_pkg holds:
  - FSM state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Mode constants: MODE_ADD = 1'b0, MODE_SUB = 1'b1.
  - A width helper for the counter, $clog2 of NCHUNK, minimum 1 bit.
- Sub-module chunk_adder, parameter CHUNK, purely combinational ripple of 1-bit full adders.
  - Ports: a, b, cin; sum, cout, and c_msb (carry into its top bit, used for overflow).
- All state lives in seq_addsub: FSM, k, A, B', c, sum and flag registers.

## Test plan
- Add overflow to zero (WIDTH=32, CHUNK=4): a=0xFFFFFFFF, b=0x00000001, carryin=0, sub=0.
  - out_valid exactly 8 cycles after accept.
  - sum=0x00000000, carryout=1, overflow=0, zero=1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add.
  - sum=0x80000000, carryout=0, overflow=1, zero=0.
- Subtract with borrow: a=5, b=7, sub=1, carryin=0.
  - sum=0xFFFFFFFE, carryout=0, overflow=0.
  - Then a=7, b=5, carryin=1: sum=0x00000001, carryout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Outputs stay constant and in_ready stays 0.
  - A new in_valid pulse is ignored.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-RUN: assert reset for 1 cycle at k=3.
  - Next cycle: in_ready=1, out_valid=0, sum=0, all flags 0.
  - A following a=1, b=1 returns sum=2 after 8 cycles.
- Parameter sweep: WIDTH=8, CHUNK=8 (latency 1) and WIDTH=8, CHUNK=1 (latency 8).
  - Random a/b/sub/carryin vectors match the reference model a ± b ± cin, including the carryout and overflow flags.
